// File: rtl/jump_ctrl.sv
// Control-transfer sequencer: computes JAL/JALR/branch targets, redirects fetch, holds flush, writes link.
// Optional `MISALIGN_TRAP_EN routes misaligned targets to a trap; otherwise targets are word-aligned.
module jump_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_taken,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] Immediate,
  input  logic [XLEN-1:0] Rd1,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_tval,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_TRAP, S_FLUSH} state_t;

  localparam logic [1:0] OP_JAL    = 2'b00;
  localparam logic [1:0] OP_JALR   = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FLUSH_INIT = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] link_data_q, link_data_d;
  logic            link_valid_q, link_valid_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] pc_sum, rs_sum, target_raw, target_new;
  logic            is_link, is_taken, goes_trap;

  // Op 11 falls through as a never-taken branch.
  always_comb begin
    pc_sum     = req_pc + Immediate;
    rs_sum     = Rd1 + Immediate;
    target_raw = (req_op == OP_JALR) ? {rs_sum[XLEN-1:1], 1'b0} : pc_sum;
    is_link    = (req_op == OP_JAL) || (req_op == OP_JALR);
    is_taken   = is_link || ((req_op == OP_BRANCH) && req_taken);
`ifdef MISALIGN_TRAP_EN
    target_new = target_raw;
    goes_trap  = target_raw[1];
`else
    target_new = target_raw & ~XLEN'(3);
    goes_trap  = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    link_data_d  = link_data_q;
    link_valid_d = 1'b0;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          target_d    = target_new;
          link_data_d = req_pc + XLEN'(4);
          if (!is_taken) begin
            done_d = 1'b1;
          end else if (goes_trap) begin
            state_d = S_TRAP;
          end else begin
            state_d      = S_REDIRECT;
            link_valid_d = is_link;
          end
        end
      end
      S_REDIRECT: begin
        if (redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end
      end
      S_TRAP: begin
        if (FLUSH_CYCLES == 0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      link_data_q  <= '0;
      link_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      link_data_q  <= link_data_d;
      link_valid_q <= link_valid_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  // Data outputs are gated by their strobes so idle buses read as zero.
  assign req_ready   = (state_q == S_IDLE);
  assign redir_valid = (state_q == S_REDIRECT);
  assign redir_pc    = redir_valid ? target_q : '0;
  assign flush       = (state_q == S_FLUSH);
  assign link_valid  = link_valid_q;
  assign link_data   = link_valid_q ? link_data_q : '0;
  assign done        = done_q;

`ifdef MISALIGN_TRAP_EN
  assign trap_valid = (state_q == S_TRAP);
  assign trap_tval  = trap_valid ? target_q : '0;
`else
  assign trap_valid = 1'b0;
  assign trap_tval  = '0;
`endif

endmodule
